// File: rtl/pre_mem_wr_resp.sv
// pre_mem_wr_resp: stages PRE output words and bursts them into the shared SRAM on request
module pre_mem_wr_resp #(
  parameter int DEPTH = 16,
  parameter int SAW = 16,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int IW = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           PRE_WR_BUF,
  input  logic [31:0]    PRE_DIN,
  input  logic           PRE_REQ,
  input  logic [3:0]     PRE_CMD,
  input  logic [31:0]    PRE_ADDR,
  output logic           MEM_PRE_SEL,
  output logic           MEM_FIN,
  input  logic           MEM_BUSY,
  output logic           SRAM_CE,
  output logic           SRAM_WE,
  output logic [SAW-1:0] SRAM_ADDR,
  output logic [31:0]    SRAM_WDATA,
  output logic [CW-1:0]  BUF_CNT,
  output logic           ERR_OVF,
  output logic           ERR_CMD,
  output logic           ERR_PROTO
);
  typedef enum logic [1:0] {IDLE, GRANT, WRITE, FIN} state_t;
  state_t state, state_n;
  logic armed, push_ok, accept, cmd_ok, unused_addr;
  logic [3:0] cmd;
  logic [SAW-1:0] base;
  logic [CW-1:0] n;
  logic [IW-1:0] idx, idx_n;
  logic [31:0] mem [DEPTH];
  assign unused_addr = ^PRE_ADDR;
  assign push_ok = state == IDLE && PRE_WR_BUF && BUF_CNT != CW'(DEPTH);
  assign accept = state == IDLE && PRE_REQ && armed && !MEM_BUSY;
  assign cmd_ok = cmd == 4'h1 || cmd == 4'h3;
  always_comb begin
    state_n = state;
    idx_n = idx;
    case (state)
      IDLE: state_n = accept ? GRANT : IDLE;
      GRANT: begin
        state_n = (cmd == 4'h1 && n != '0) ? WRITE : FIN;
        idx_n = '0;
      end
      WRITE: begin
        state_n = (CW'(idx) == n - CW'(1)) ? FIN : WRITE;
        idx_n = idx + IW'(1);
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      armed <= 1'b1;
      cmd <= '0;
      base <= '0;
      n <= '0;
      idx <= '0;
      BUF_CNT <= '0;
      MEM_PRE_SEL <= 1'b0;
      MEM_FIN <= 1'b0;
      SRAM_CE <= 1'b0;
      SRAM_WE <= 1'b0;
      SRAM_ADDR <= '0;
      SRAM_WDATA <= '0;
      ERR_OVF <= 1'b0;
      ERR_CMD <= 1'b0;
      ERR_PROTO <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      MEM_PRE_SEL <= state_n != IDLE;
      MEM_FIN <= state_n == FIN;
      SRAM_CE <= state_n == WRITE;
      SRAM_WE <= state_n == WRITE;
      SRAM_ADDR <= state_n == WRITE ? base + SAW'(idx_n) : '0;
      SRAM_WDATA <= state_n == WRITE ? mem[idx_n] : '0;
      armed <= !PRE_REQ ? 1'b1 : accept ? 1'b0 : armed;
      if (accept) begin
        cmd <= PRE_CMD;
        base <= PRE_ADDR[SAW-1:0];
        n <= BUF_CNT + CW'(push_ok);
      end
      if (push_ok)
        BUF_CNT <= BUF_CNT + CW'(1);
      else if (state == FIN && cmd_ok)
        BUF_CNT <= '0;
      if (state == IDLE && PRE_WR_BUF && !push_ok) ERR_OVF <= 1'b1;
      if (state != IDLE && PRE_WR_BUF) ERR_PROTO <= 1'b1;
      if (state == GRANT && !cmd_ok) ERR_CMD <= 1'b1;
    end
  end
  always_ff @(posedge clk) if (push_ok) mem[BUF_CNT[IW-1:0]] <= PRE_DIN;
endmodule

// File: tb/tb_pre_mem_wr_resp.sv
// tb_pre_mem_wr_resp: directed bench with a transaction-schedule model of the PRE write responder
module tb_pre_mem_wr_resp;
  localparam int DEPTH = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic wr = 1'b0, req = 1'b0, busy = 1'b0;
  logic [31:0] din = '0, addr = '0;
  logic [3:0] cmd = '0;
  logic sel, fin, ce, we, e_ovf_d, e_cmd_d, e_proto_d;
  logic [15:0] sa;
  logic [31:0] sd;
  logic [4:0] cnt;
  pre_mem_wr_resp #(.DEPTH(DEPTH), .SAW(16)) dut (
    .clk(clk), .rst(rst), .PRE_WR_BUF(wr), .PRE_DIN(din), .PRE_REQ(req),
    .PRE_CMD(cmd), .PRE_ADDR(addr), .MEM_PRE_SEL(sel), .MEM_FIN(fin),
    .MEM_BUSY(busy), .SRAM_CE(ce), .SRAM_WE(we), .SRAM_ADDR(sa),
    .SRAM_WDATA(sd), .BUF_CNT(cnt), .ERR_OVF(e_ovf_d), .ERR_CMD(e_cmd_d),
    .ERR_PROTO(e_proto_d)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_err = 0, cyc = 0;
  bit m_on = 1'b0, armed, m_ovf, m_cmd_err, m_proto;
  int g_c, fin_c, nw;
  logic [3:0] m_cmd;
  logic [15:0] m_base;
  logic [31:0] q[$], words[$];
  logic [31:0] mem_log [logic [15:0]];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  initial forever begin
    int cur;
    bit idle, acc;
    @(posedge clk);
    cur = cyc;
    if (rst) begin
      q.delete();
      armed = 1'b1;
      {m_ovf, m_cmd_err, m_proto} = '0;
      g_c = -100;
      fin_c = -100;
      nw = 0;
      m_on = 1'b1;
    end else if (m_on) begin
      idle = cur > fin_c;
      if (wr) begin
        if (!idle) m_proto = 1'b1;
        else if (q.size() < DEPTH) q.push_back(din);
        else m_ovf = 1'b1;
      end
      if (cur == g_c && !(m_cmd == 4'h1 || m_cmd == 4'h3)) m_cmd_err = 1'b1;
      if (cur == fin_c && (m_cmd == 4'h1 || m_cmd == 4'h3)) q.delete();
      acc = idle && req && armed && !busy;
      if (!req) armed = 1'b1;
      else if (acc) armed = 1'b0;
      if (acc) begin
        m_cmd = cmd;
        m_base = addr[15:0];
        g_c = cur + 1;
        nw = cmd == 4'h1 ? q.size() : 0;
        words = q;
        fin_c = g_c + (nw > 0 ? nw + 1 : 1);
      end
    end
    cyc = cyc + 1;
  end
  initial forever begin
    bit x_ce;
    int k;
    @(negedge clk);
    if (m_on) begin
      x_ce = cyc > g_c && cyc <= g_c + nw;
      k = cyc - g_c - 1;
      check("sel", 32'(sel), 32'(cyc >= g_c && cyc <= fin_c));
      check("fin", 32'(fin), 32'(cyc == fin_c));
      check("ce", 32'(ce), 32'(x_ce));
      check("we", 32'(we), 32'(x_ce));
      check("addr", 32'(sa), x_ce ? 32'(16'(m_base + 16'(k))) : 32'h0);
      check("wdata", sd, x_ce ? words[k] : 32'h0);
      check("buf_cnt", 32'(cnt), 32'(q.size()));
      check("err_ovf", 32'(e_ovf_d), 32'(m_ovf));
      check("err_cmd", 32'(e_cmd_d), 32'(m_cmd_err));
      check("err_proto", 32'(e_proto_d), 32'(m_proto));
      if (ce) mem_log[sa] = sd;
    end
  end
  task automatic push(input logic [31:0] d);
    wr = 1'b1;
    din = d;
    @(negedge clk);
    wr = 1'b0;
  endtask
  task automatic wait_fin(output int f);
    bit seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (fin) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      wr = 1'b0;
    end
    f = cyc;
    if (!seen) begin
      n_chk++;
      n_err++;
      $display("FAIL fin_timeout: got no MEM_FIN expected one within 64 cycles");
    end
  endtask
  task automatic release_req();
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
  endtask
  task automatic do_req(input logic [3:0] c, input logic [31:0] a, input bit pw,
                        input logic [31:0] pd, output int lat);
    int r, f;
    req = 1'b1;
    cmd = c;
    addr = a;
    wr = pw;
    din = pd;
    r = cyc;
    wait_fin(f);
    lat = f - r;
    release_req();
  endtask
  function automatic logic [31:0] logged(input logic [15:0] a);
    return mem_log.exists(a) ? mem_log[a] : 32'hDEAD_BEEF;
  endfunction
  initial begin
    int lat, r, f;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_cnt", 32'(cnt), 0);
    check("rst_sel", 32'(sel), 0);
    check("rst_ovf", 32'(e_ovf_d), 0);
    for (int i = 0; i < 4; i++) push(32'hA0 + 32'(i));
    do_req(4'h1, 32'h100, 1'b0, 0, lat);
    #1;
    check("t1_lat", 32'(lat), 6);
    check("t1_w0", logged(16'h100), 32'hA0);
    check("t1_w3", logged(16'h103), 32'hA3);
    check("t1_cnt", 32'(cnt), 0);
    for (int i = 0; i < 17; i++) push(32'h1000 + 32'(i));
    #1;
    check("t2_ovf", 32'(e_ovf_d), 1);
    check("t2_cnt", 32'(cnt), 16);
    do_req(4'h1, 32'h0001_FFF8, 1'b0, 0, lat);
    #1;
    check("t2_lat", 32'(lat), 18);
    check("t2_ffff", logged(16'hFFFF), 32'h1007);
    check("t2_0000", logged(16'h0000), 32'h1008);
    check("t2_0007", logged(16'h0007), 32'h100F);
    push(32'hB0);
    push(32'hB1);
    busy = 1'b1;
    req = 1'b1;
    cmd = 4'h1;
    addr = 32'h200;
    repeat (5) @(negedge clk);
    #1;
    check("t3_busy_sel", 32'(sel), 0);
    busy = 1'b0;
    r = cyc;
    @(negedge clk);
    #1;
    check("t3_grant_sel", 32'(sel), 1);
    busy = 1'b1;
    wait_fin(f);
    check("t3_lat", 32'(f - r), 4);
    busy = 1'b0;
    release_req();
    #1;
    check("t3_w1", logged(16'h201), 32'hB1);
    push(32'hC0);
    push(32'hC1);
    do_req(4'h1, 32'h300, 1'b1, 32'hC2, lat);
    #1;
    check("t4_lat", 32'(lat), 5);
    check("t4_w2", logged(16'h302), 32'hC2);
    push(32'hD0);
    req = 1'b1;
    cmd = 4'h1;
    addr = 32'h400;
    r = cyc;
    repeat (2) @(negedge clk);
    wr = 1'b1;
    din = 32'hDEAD;
    @(negedge clk);
    wr = 1'b0;
    wait_fin(f);
    check("t4b_lat", 32'(f - r), 3);
    release_req();
    #1;
    check("t4b_proto", 32'(e_proto_d), 1);
    check("t4b_cnt", 32'(cnt), 0);
    check("t4b_w0", logged(16'h400), 32'hD0);
    check("t4b_nowr", 32'(mem_log.exists(16'h401)), 0);
    for (int i = 0; i < 3; i++) push(32'hE0 + 32'(i));
    do_req(4'h7, 32'h500, 1'b0, 0, lat);
    #1;
    check("t5_lat", 32'(lat), 2);
    check("t5_errcmd", 32'(e_cmd_d), 1);
    check("t5_cnt", 32'(cnt), 3);
    check("t5_nowr", 32'(mem_log.exists(16'h500)), 0);
    do_req(4'h3, 32'h600, 1'b0, 0, lat);
    #1;
    check("t5_clr_lat", 32'(lat), 2);
    check("t5_clr_cnt", 32'(cnt), 0);
    req = 1'b1;
    cmd = 4'h3;
    wait_fin(f);
    repeat (6) @(negedge clk);
    #1;
    check("t5_no_retrig", 32'(sel), 0);
    req = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) push(32'hF0 + 32'(i));
    req = 1'b1;
    cmd = 4'h1;
    addr = 32'h700;
    for (int i = 0; i < 16 && !ce; i++) @(negedge clk);
    check("t6_started", 32'(ce), 1);
    @(negedge clk);
    rst = 1'b1;
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t6_ce", 32'(ce), 0);
    check("t6_sel", 32'(sel), 0);
    check("t6_cnt", 32'(cnt), 0);
    check("t6_flags", 32'({e_ovf_d, e_cmd_d, e_proto_d}), 0);
    check("t6_w1", logged(16'h701), 32'hF1);
    check("t6_nowr", 32'(mem_log.exists(16'h702)), 0);
    repeat (12) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/pre_mem_wr_resp.md
# pre_mem_wr_resp

Memory-controller-side responder for the pooling/encoding (PRE) engine's write port. Captures PRE output words into a local staging buffer via `PRE_WR_BUF`/`PRE_DIN`. On a `PRE_REQ` it arbitrates for the SRAM, bursts the buffered words to `PRE_ADDR` onward, and signals completion with `MEM_FIN`. It sits between the PRE engine and the shared feature-map SRAM, alongside the other memory-controller masters.

## Interface
- `DEPTH`, 16: staging-buffer depth in 32-bit words (power of two, 2..64)
- `SAW`, 16: SRAM word-address width
- `clk` input 1: single clock, rising edge
- `rst` input 1: synchronous, active-high reset
- `PRE_WR_BUF` input 1: one-cycle strobe; push `PRE_DIN` into the buffer
- `PRE_DIN` input 32: data word for the buffer
- `PRE_REQ` input 1: level request, held by PRE until it samples `MEM_FIN`
- `PRE_CMD` input 4: 4'h1 WRITE, 4'h3 CLEAR; all other values are illegal
- `PRE_ADDR` input 32: SRAM word base address; only `[SAW-1:0]` is used
- `MEM_PRE_SEL` output 1: high while this block owns the SRAM (GRANT through FIN)
- `MEM_FIN` output 1: one-cycle completion pulse
- `MEM_BUSY` input 1: another master holds the SRAM; blocks acceptance
- `SRAM_CE`, `SRAM_WE` output 1: SRAM chip enable and write enable
- `SRAM_ADDR` output SAW: SRAM write address
- `SRAM_WDATA` output 32: SRAM write data
- `BUF_CNT` output $clog2(DEPTH+1): current buffer occupancy
- `ERR_OVF`, `ERR_CMD`, `ERR_PROTO` output 1: sticky error flags, cleared only by `rst`

## Operation
- FSM states: IDLE, GRANT, WRITE, FIN. Reset state is IDLE.
- Buffer fill happens only in IDLE. On `PRE_WR_BUF`, store to `buf[BUF_CNT]` and increment `BUF_CNT`.
  - If `BUF_CNT==DEPTH`, drop the word and set `ERR_OVF`.
  - A `PRE_WR_BUF` strobe outside IDLE is dropped and sets `ERR_PROTO`.
- `armed` flag: set when `PRE_REQ` is sampled low, cleared on entering GRANT. Reset value 1. A request still held high after FIN cannot retrigger.
- IDLE -> GRANT when `PRE_REQ && armed && !MEM_BUSY`. On that edge, latch:
  - `cmd <= PRE_CMD`
  - `base <= PRE_ADDR[SAW-1:0]`
  - `n <= BUF_CNT + (PRE_WR_BUF && BUF_CNT<DEPTH)`
  - A same-cycle push is therefore included in the burst.
- GRANT actions and exit, by `cmd`:
  - WRITE with `n>0`: `idx <= 0`, go to WRITE.
  - WRITE with `n==0`: go to FIN; no SRAM access.
  - CLEAR: go to FIN.
  - Illegal command: set `ERR_CMD`, go to FIN; buffer retained.
- WRITE: each cycle drive `SRAM_CE=SRAM_WE=1`, `SRAM_ADDR=base+idx` (mod 2^SAW, wraps silently), `SRAM_WDATA=buf[idx]`, then `idx++`. Go to FIN when `idx==n-1`.
- FIN: `MEM_FIN=1` for exactly one cycle. `BUF_CNT<=0` for WRITE/CLEAR, unchanged for an illegal command. Then go to IDLE.
- `MEM_BUSY` is ignored once GRANT is entered; ownership is non-preemptive.
- Reset mid-operation: next edge returns to IDLE with `BUF_CNT=0`. No `MEM_FIN` is issued, SRAM strobes drop, `armed=1`, and error flags clear.

## Timing
- Reset values: every output is 0, and all SRAM outputs are 0.
- `MEM_PRE_SEL` is registered: high in GRANT, WRITE and FIN; low in IDLE.
- SRAM outputs are registered and are zero in every cycle that `SRAM_CE` is low.
- Request sampled at edge t (IDLE) → GRANT in cycle t+1 → WRITE in cycles t+2..t+n+1 → `MEM_FIN` in cycle t+n+2. Total latency is n+2 cycles; for n==0, CLEAR or an illegal command, `MEM_FIN` is in cycle t+2.
- PRE drops `PRE_REQ` the cycle after sampling `MEM_FIN`; `armed` re-arms on that low sample.
- Earliest next acceptance is 2 cycles after the `MEM_FIN` cycle.
- Pushes resume in the IDLE cycle immediately after FIN.
- Throughput: one SRAM write per cycle, no bubbles.

## Test plan
- Push 4 words `0xA0..0xA3`, then REQ WRITE with ADDR=0x100 and BUSY=0 → SRAM writes 0x100..0x103 with matching data in 4 consecutive cycles, `MEM_FIN` 6 cycles after acceptance, `BUF_CNT=0`.
- Push 16 words, then a 17th → `ERR_OVF=1`, `BUF_CNT=16`. A following WRITE at ADDR=0xFFF8 (SAW=16) writes 16 words with address wrap 0xFFFF→0x0000.
- Hold `MEM_BUSY=1` for 5 cycles with REQ high → `MEM_PRE_SEL` stays low. Deassert BUSY → GRANT next cycle. Reasserting BUSY during WRITE does not stall the burst.
- Push in the same cycle the REQ is accepted with `BUF_CNT=2` → burst length 3. A push during WRITE → dropped, `ERR_PROTO=1`.
- `PRE_CMD=4'h7` with 3 words buffered → `MEM_FIN` at t+2, `ERR_CMD=1`, `BUF_CNT=3`, no SRAM writes. CLEAR then gives `BUF_CNT=0`. Holding REQ high after FIN does not retrigger.
- Assert `rst` at the 2nd WRITE cycle of an 8-word burst → SRAM_CE low next cycle, no `MEM_FIN`, `BUF_CNT=0`, all flags 0.
